// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned AddrWidth    = 8;
    localparam int unsigned InstWidth    = 16;
    localparam int unsigned DefaultDepth = 4;

    // Fetch FSM states
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    // Prefetch queue entry: {pc, inst}, 24 bits
    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        logic [InstWidth-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries. Flush wins over push/pop.
// The head reads as zero while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned CntWidth = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  fetch_entry_t        push_entry,
    input  logic                pop,
    input  logic                flush,
    output logic [CntWidth-1:0] count,
    output fetch_entry_t        head
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t          mem_q [DEPTH];
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [CntWidth-1:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && (count_q != CntWidth'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is gated by count
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= push_entry;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential fetch FSM, prefetch queue, branch redirect.
// Optional build macro FETCH_PERF_EN adds saturating fetch/discard counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [AddrWidth-1:0] RESET_PC = 8'h00,
    parameter int unsigned          DEPTH    = DefaultDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_rd_en,
    output logic [AddrWidth-1:0] imem_addr,
    input  logic                 imem_rd_rdy,
    input  logic [InstWidth-1:0] imem_inst,
    input  logic                 redirect,
    input  logic [AddrWidth-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [InstWidth-1:0] inst_out,
    output logic [AddrWidth-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          perf_fetches,
    output logic [15:0]          perf_discards
`endif
);

    localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

    fetch_state_e         state_q;
    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 rd_en_q;
    logic [CntWidth-1:0]  q_count;
    fetch_entry_t         q_head;
    fetch_entry_t         push_entry;
    logic                 can_issue;
    logic                 push;
    logic                 pop;

    assign can_issue  = q_count < CntWidth'(DEPTH);
    // A response is kept only if no redirect has hit the request it belongs to
    assign push       = (state_q == StReq) && imem_rd_rdy && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign push_entry = '{pc: addr_q, inst: imem_inst};

    // Fetch FSM: one outstanding request, an idle gap after each, redirect-aware
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            rd_en_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end else if (can_issue) begin
                        state_q <= StReq;
                        addr_q  <= pc_q;
                        rd_en_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (redirect) begin
                        pc_q <= redirect_pc;
                        if (imem_rd_rdy) begin
                            state_q <= StIdle;
                            rd_en_q <= 1'b0;
                        end else begin
                            // Request cannot be cancelled; wait out its response
                            state_q <= StDiscard;
                        end
                    end else if (imem_rd_rdy) begin
                        pc_q    <= pc_q + AddrWidth'(1);
                        state_q <= StIdle;
                        rd_en_q <= 1'b0;
                    end
                end
                StDiscard: begin
                    if (redirect) pc_q <= redirect_pc;
                    if (imem_rd_rdy) begin
                        state_q <= StIdle;
                        rd_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH    (DEPTH),
        .CntWidth (CntWidth)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (q_count),
        .head       (q_head)
    );

    assign imem_rd_en = rd_en_q;
    assign imem_addr  = addr_q;
    assign inst_valid = q_count != '0;
    assign inst_out   = q_head.inst;
    assign inst_pc    = q_head.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetches_q;
    logic [15:0] perf_discards_q;
    logic        drop;

    assign drop = imem_rd_rdy && (((state_q == StReq) && redirect) || (state_q == StDiscard));

    // Saturating counters of kept and dropped responses
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetches_q  <= '0;
            perf_discards_q <= '0;
        end else begin
            if (push && (perf_fetches_q != 16'hFFFF))  perf_fetches_q  <= perf_fetches_q + 16'd1;
            if (drop && (perf_discards_q != 16'hFFFF)) perf_discards_q <= perf_discards_q + 16'd1;
        end
    end

    assign perf_fetches  = perf_fetches_q;
    assign perf_discards = perf_discards_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory hierarchy model with variable latency,
// queue-based reference model of delivered instructions, directed tables and random traffic.
module tb_instr_fetch_unit;

    localparam logic [7:0] RstPc = 8'h10;
    localparam int         Depth = 4;

    logic        clk;
    logic        rst;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic        imem_rd_rdy;
    logic [15:0] imem_inst;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_out;
    logic [7:0]  inst_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetches;
    logic [15:0] perf_discards;
`endif

    instr_fetch_unit #(
        .RESET_PC (RstPc),
        .DEPTH    (Depth)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rd_rdy (imem_rd_rdy),
        .imem_inst   (imem_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetches  (perf_fetches),
        .perf_discards (perf_discards)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [15:0] inst_of(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // Hierarchy model state
    bit         h_busy = 0;
    bit         h_new  = 0;
    logic [7:0] h_addr;
    int         h_rem;
    int         lat_fix = 1;

    // Reference model: what decode should see
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] inst;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] acc[$];
    bit         m_out  = 0;
    bit         m_gap  = 0;
    bit         m_live = 0;
    logic [7:0] m_addr;
    logic [7:0] m_pc   = RstPc;
    int         m_fetch = 0;
    int         m_drop  = 0;

    // One clock cycle: check at negedge, update model at posedge, drive hierarchy after it
    task automatic cycle();
        logic s_valid;
        ent_t e;
        @(negedge clk);
        s_valid = inst_valid;
        chk("valid", 32'(s_valid), 32'(mq.size() != 0));
        if (s_valid && mq.size() != 0) begin
            chk("head_pc", 32'(inst_pc), 32'(mq[0].pc));
            chk("head_inst", 32'(inst_out), 32'(mq[0].inst));
        end
        if (m_out) begin
            chk("rd_en_hold", 32'(imem_rd_en), 32'd1);
            chk("addr_hold", 32'(imem_addr), 32'(m_addr));
        end else if (m_gap) begin
            chk("rd_en_gap", 32'(imem_rd_en), 32'd0);
        end
        if (!m_out && imem_rd_en) begin
            chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
            m_out  = 1;
            m_addr = imem_addr;
            m_live = 1;
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetches", 32'(perf_fetches), (m_fetch > 65535) ? 32'hFFFF : 32'(m_fetch));
        chk("perf_discards", 32'(perf_discards), (m_drop > 65535) ? 32'hFFFF : 32'(m_drop));
`endif
        @(posedge clk);
        m_gap = 0;
        if (rst) begin
            mq.delete();
            m_out   = 0;
            m_live  = 0;
            m_pc    = RstPc;
            m_fetch = 0;
            m_drop  = 0;
        end else begin
            if (s_valid && inst_ready && !redirect && mq.size() != 0) begin
                e = mq.pop_front();
                acc.push_back(e.pc);
            end
            if (m_out && imem_rd_rdy) begin
                m_out = 0;
                m_gap = 1;
                if (m_live && !redirect) begin
                    mq.push_back('{pc: m_pc, inst: imem_inst});
                    m_pc = m_pc + 8'd1;
                    m_fetch++;
                end else begin
                    m_drop++;
                end
            end
            if (redirect) begin
                mq.delete();
                m_pc   = redirect_pc;
                m_live = 0;
            end
        end
        #1;
        h_new       = 0;
        imem_rd_rdy = 1'b0;
        imem_inst   = 16'($urandom);
        if (!h_busy && imem_rd_en && !rst) begin
            h_busy = 1;
            h_new  = 1;
            h_addr = imem_addr;
            h_rem  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
        end
        if (h_busy) begin
            if (h_rem <= 1) begin
                imem_rd_rdy = 1'b1;
                imem_inst   = inst_of(h_addr);
                h_busy      = 0;
            end else begin
                h_rem--;
            end
        end
    endtask

    task automatic wait_new_req(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (h_new) return;
        end
        fail_timeout(name);
    endtask

    task automatic wait_accepts(input string name, input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (acc.size() >= n) return;
            cycle();
        end
        fail_timeout(name);
    endtask

    task automatic check_acc_seq(input string name, input logic [7:0] start, input int n);
        logic [7:0] e;
        for (int i = 0; i < n && i < acc.size(); i++) begin
            e = start + 8'(i);
            chk(name, 32'(acc[i]), 32'(e));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_en"}, 32'(imem_rd_en), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(RstPc));
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst_out"}, 32'(inst_out), 32'd0);
        chk({tag, "_inst_pc"}, 32'(inst_pc), 32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetches"}, 32'(perf_fetches), 32'd0);
        chk({tag, "_perf_discards"}, 32'(perf_discards), 32'd0);
`endif
    endtask

    typedef struct {
        logic [7:0] target;
        int         lat;
        int         n;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        bit found;
        int f0;
        logic [7:0] last;

        vecs[0] = '{target: 8'hFE, lat: 1, n: 4, exp_last: 8'h01};
        vecs[1] = '{target: 8'h40, lat: 3, n: 3, exp_last: 8'h42};
        vecs[2] = '{target: 8'hFF, lat: 2, n: 2, exp_last: 8'h00};
        vecs[3] = '{target: 8'h7C, lat: 5, n: 5, exp_last: 8'h80};

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        inst_ready  = 1'b0;
        imem_rd_rdy = 1'b0;
        imem_inst   = 16'h0000;
        repeat (3) cycle();
        check_reset_values("reset");

        // Straight-line fetch with 1-cycle hits: request, gap, request, ...
        rst        = 1'b0;
        inst_ready = 1'b1;
        lat_fix    = 1;
        acc.delete();
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("gap_pattern", 32'(imem_rd_en), 32'(k % 2 == 0));
        end
        wait_accepts("straight_accepts", 6, 20);
        check_acc_seq("straight_pc", RstPc, 6);

        // Redirect table, including wrap-around of the 8-bit pc
        foreach (vecs[v]) begin
            lat_fix     = vecs[v].lat;
            redirect    = 1'b1;
            redirect_pc = vecs[v].target;
            acc.delete();
            cycle();
            redirect = 1'b0;
            wait_accepts("table_accepts", vecs[v].n, 200);
            check_acc_seq("table_pc", vecs[v].target, vecs[v].n);
            last = (acc.size() >= vecs[v].n) ? acc[vecs[v].n - 1] : 8'hxx;
            chk("table_last_pc", 32'(last), 32'(vecs[v].exp_last));
        end

        // Backpressure: exactly DEPTH pushes then no more requests
        lat_fix     = 0;
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        cycle();
        redirect = 1'b0;
        f0 = m_fetch;
        repeat (40) cycle();
        chk("bp_pushes", 32'(m_fetch - f0), 32'(Depth));
        chk("bp_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("bp_rd_en_idle", 32'(imem_rd_en), 32'd0);
        end
        acc.delete();
        inst_ready = 1'b1;
        wait_accepts("bp_accepts", 8, 200);
        check_acc_seq("bp_pc", 8'h20, 8);

        // Redirect three cycles into a 10-cycle miss
        lat_fix = 10;
        wait_new_req("miss_req", 60);
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !imem_rd_rdy; i++) begin
            cycle();
            chk("miss_valid_low", 32'(inst_valid), 32'd0);
        end
        chk("miss_response_seen", 32'(imem_rd_rdy), 32'd1);
        acc.delete();
        cycle();
        chk("miss_drop", 32'(inst_valid), 32'd0);
        wait_new_req("miss_refetch", 10);
        chk("miss_refetch_addr", 32'(imem_addr), 32'h40);
        wait_accepts("miss_accept", 1, 40);
        check_acc_seq("miss_pc", 8'h40, 1);

        // Redirect together with a response and a pop
        lat_fix    = 1;
        inst_ready = 1'b0;
        repeat (25) cycle();
        inst_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_rd_rdy && inst_valid) found = 1;
            else cycle();
        end
        if (!found) fail_timeout("simul_setup");
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        acc.delete();
        cycle();
        redirect = 1'b0;
        chk("simul_flush", 32'(inst_valid), 32'd0);
        wait_new_req("simul_refetch", 10);
        chk("simul_refetch_addr", 32'(imem_addr), 32'h80);
        wait_accepts("simul_accepts", 2, 40);
        check_acc_seq("simul_pc", 8'h80, 2);

        // Random traffic against the reference model
        lat_fix = 0;
        for (int i = 0; i < 1500; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = 8'($urandom);
            cycle();
        end
        redirect = 1'b0;

        // Reset during DISCARD with the late response arriving under reset
        lat_fix    = 12;
        inst_ready = 1'b1;
        wait_new_req("rst_req", 40);
        cycle();
        redirect    = 1'b1;
        redirect_pc = 8'h55;
        cycle();
        redirect = 1'b0;
        cycle();
        rst   = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (!h_busy) found = 1;
        end
        if (!found) fail_timeout("rst_late_response");
        chk("rst_late_rd_en", 32'(imem_rd_en), 32'd0);
        cycle();
        check_reset_values("midreset");
        rst     = 1'b0;
        lat_fix = 1;
        acc.delete();
        cycle();
        chk("post_rst_rd_en", 32'(imem_rd_en), 32'd1);
        chk("post_rst_addr", 32'(imem_addr), 32'(RstPc));
        wait_accepts("post_rst_accepts", 2, 20);
        check_acc_seq("post_rst_pc", RstPc, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- **Purpose.** Processor-side initiator for the instruction memory hierarchy (2-way instruction cache backed by off-chip memory).
- **Fetch.** Generates sequential 8-bit word addresses and drives the hierarchy's rd_en/addr/rd_rdy/inst handshake, one request outstanding at a time.
- **Buffering.** Returned 16-bit instructions go into a small prefetch queue that feeds decode through a valid/ready handshake.
- **Redirect.** Branch redirects flush the queue and discard any in-flight response.

## Interface
- RESET_PC, 8'h00, first fetch address after reset
- DEPTH, 4, prefetch queue entries (power of two, 2..16)
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- imem_rd_en  output  1  read request to hierarchy
- imem_addr  output  8  word address of request
- imem_rd_rdy  input  1  one-cycle pulse: imem_inst valid
- imem_inst  input  16  returned instruction
- redirect  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  8  new fetch address, sampled when redirect=1
- inst_valid  output  1  queue head valid
- inst_ready  input  1  decode accepts head
- inst_out  output  16  queue head instruction
- inst_pc  output  8  address of inst_out

## Operation
- **FSM states**
  - IDLE: imem_rd_en=0; the mandatory gap state.
  - REQ: imem_rd_en=1, imem_addr held stable.
  - DISCARD: imem_rd_en=1, imem_addr held; the response will be dropped.
- **IDLE → REQ** when count < DEPTH and redirect=0.
  - imem_addr <= pc on entry.
  - On redirect in IDLE: pc <= redirect_pc, stay IDLE one cycle.
- **REQ, imem_rd_rdy=1, redirect=0**
  - Push {pc, imem_inst}.
  - pc <= pc+1, mod 256: 8'hFF wraps to 8'h00.
  - Go to IDLE.
- **REQ, redirect=1 (with or without imem_rd_rdy)**
  - Flush queue, pc <= redirect_pc.
  - With imem_rd_rdy: data dropped, go to IDLE.
  - Without imem_rd_rdy: go to DISCARD.
- **DISCARD**
  - On imem_rd_rdy: drop data, go to IDLE.
  - Redirect in DISCARD: pc <= redirect_pc, state unchanged, queue flushed.
- **Protocol rules**
  - imem_rd_en and imem_addr never change while a request is outstanding; requests are never cancelled.
  - At least one idle cycle between requests.
  - imem_rd_rdy outside REQ/DISCARD is ignored.
- **Queue**
  - inst_valid = (count != 0); inst_out/inst_pc come from the head.
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push never occurs when full: the issue condition guarantees space.
- **Redirect priority:** redirect beats push and pop in the same cycle; a pop in that cycle is discarded.

## Timing
- **Reset values:** imem_rd_en=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, state=IDLE, count=0, pc=RESET_PC.
- **First request:** imem_rd_en rises the first cycle after rst is deasserted.
- **Response to decode:** instruction captured on the imem_rd_rdy edge; inst_valid=1 on the next cycle when the queue was empty.
- **Minimum request period:** hit latency L cycles + 1 gap cycle.
- **Flush visibility:** inst_valid=0 the cycle after redirect.
- **Refetch:** first new-path request no earlier than 2 cycles after redirect (REQ case) or after the pending response (DISCARD case).
- **Reset mid-request:** FSM returns to IDLE. The response still in flight from the hierarchy arrives while imem_rd_en=0 and is ignored; the hierarchy is reset by the same rst.

## Configuration
- **FETCH_PERF_EN defined:** adds outputs perf_fetches[15:0] and perf_discards[15:0].
  - perf_fetches counts pushed instructions; perf_discards counts dropped responses.
  - Both saturate at 16'hFFFF and clear on rst.
- **FETCH_PERF_EN undefined:** no ports, no counters; functional behaviour is identical.

## Structure
- **Package fetch_pkg:** FSM state encoding (IDLE, REQ, DISCARD), default DEPTH, address and instruction width constants (8, 16).
- **Sub-module fetch_queue:** synchronous FIFO, 24-bit entries {pc, inst}.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push/pop.
- **Top:** instr_fetch_unit holds the FSM, pc, request registers and the optional perf counters.

## Test plan
- **Reset, straight-line fetch:** RESET_PC=8'h10, hierarchy model with 1-cycle hit, inst_ready=1 → inst_pc sequence 10,11,12…; imem_rd_en low exactly one cycle between requests; imem_addr stable while imem_rd_en=1.
- **Backpressure:** inst_ready=0, DEPTH=4 → exactly 4 pushes, then imem_rd_en stays 0. Raise inst_ready → fetching resumes at pc+4 with order preserved.
- **Redirect during 10-cycle miss:** redirect_pc=8'h40 three cycles into REQ → imem_addr held until imem_rd_rdy, response dropped (inst_valid stays 0), next request addr=8'h40.
- **Simultaneous events:** redirect together with imem_rd_rdy and a pop → queue empty next cycle, no push, next request at redirect_pc.
- **Wrap-around:** RESET_PC=8'hFE → inst_pc FE, FF, 00, 01.
- **Reset mid-miss:** assert rst during DISCARD, late imem_rd_rdy arrives → outputs at reset values, no push. With FETCH_PERF_EN: counters read 0 after rst.
